// File: rtl/btn_debounce_pkg.sv
// Shared types and defaults for the push-button debouncer.
package btn_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHK_HI = 2'd1,
        HELD   = 2'd2,
        CHK_LO = 2'd3
    } state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int DEFAULT_REPEAT_CYCLES   = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer: 2-flop sync, 4-state qualify FSM, registered level/press/release.
// Optional auto-repeat of btn_press while held is compiled in with BTN_DEBOUNCE_AUTOREPEAT_EN.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          btn_sync;
    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          level_nxt, press_nxt, release_nxt;
    logic          rep_pulse;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (btn_sync)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Every state exit clears cnt, so it never counts past CNT_LAST.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        level_nxt   = btn_level;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (btn_sync) begin
                    state_nxt = CHK_HI;
                    cnt_nxt   = '0;
                end
            end
            CHK_HI: begin
                if (!btn_sync) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                    level_nxt = 1'b1;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            HELD: begin
                if (!btn_sync) begin
                    state_nxt = CHK_LO;
                    cnt_nxt   = '0;
                end
            end
            CHK_LO: begin
                if (btn_sync) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = IDLE;
                    cnt_nxt     = '0;
                    level_nxt   = 1'b0;
                    release_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep_cnt, rep_cnt_nxt;

    // Counts only while staying in HELD; entry and exit both leave it at zero.
    always_comb begin
        rep_cnt_nxt = '0;
        rep_pulse   = 1'b0;
        if (state == HELD && state_nxt == HELD) begin
            if (rep_cnt == REP_LAST) begin
                rep_pulse = 1'b1;
            end else begin
                rep_cnt_nxt = rep_cnt + RW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_cnt_nxt;
        end
    end
`else
    logic unused_repeat;
    assign unused_repeat = |REPEAT_CYCLES;
    assign rep_pulse     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            btn_level   <= level_nxt;
            btn_press   <= press_nxt | rep_pulse;
            btn_release <= release_nxt;
        end
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8).
module tb_btn_debounce;

    localparam int DEB = 4;
    localparam int REP = 8;

    typedef struct {
        int   cyc;
        logic press;
        logic rel;
        logic level;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_in = 1'b0;
    logic btn_level, btn_press, btn_release;

    ev_t exp_q[$];
    ev_t probe_q[$];
    ev_t e, pr;
    int  edge_n = 0;
    int  checks = 0;
    int  errors = 0;
    logic prev_level = 1'b0;
    logic done = 1'b0;
    int  base;

    btn_debounce #(.DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(REP)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Output-change events are expected in order at an exact edge number.
    task automatic ev(input int cyc, input logic p, input logic r, input logic l);
        exp_q.push_back('{cyc, p, r, l});
    endtask

    // Full output snapshot expected at the negedge after edge cyc.
    task automatic probe(input int cyc, input logic p, input logic r, input logic l);
        probe_q.push_back('{cyc, p, r, l});
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor / checker
    always @(negedge clk) begin
        if (btn_press || btn_release || (btn_level != prev_level)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL event_unexpected edge=%0d got p/r/l=%b%b%b required no event",
                         edge_n, btn_press, btn_release, btn_level);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != edge_n || e.press != btn_press || e.rel != btn_release || e.level != btn_level) begin
                    errors++;
                    $display("FAIL event edge=%0d got p/r/l=%b%b%b required edge=%0d p/r/l=%b%b%b",
                             edge_n, btn_press, btn_release, btn_level, e.cyc, e.press, e.rel, e.level);
                end
            end
        end
        prev_level = btn_level;
        while (probe_q.size() != 0 && probe_q[0].cyc <= edge_n) begin
            pr = probe_q.pop_front();
            checks++;
            if (pr.cyc != edge_n || pr.press != btn_press || pr.rel != btn_release || pr.level != btn_level) begin
                errors++;
                $display("FAIL probe edge=%0d got p/r/l=%b%b%b required edge=%0d p/r/l=%b%b%b",
                         edge_n, btn_press, btn_release, btn_level, pr.cyc, pr.press, pr.rel, pr.level);
            end
        end
        if (done) begin
            checks++;
            if (exp_q.size() != 0 || probe_q.size() != 0) begin
                errors++;
                $display("FAIL pending got events=%0d probes=%0d required 0 0", exp_q.size(), probe_q.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    initial begin
        rst = 1'b1;
        btn_in = 1'b0;
        probe(2, 1'b0, 1'b0, 1'b0);
        wait_edges(3);
        rst = 1'b0;
        wait_edges(2);

        // Clean press held 40 cycles, then release
        base = edge_n;
        btn_in = 1'b1;
        ev(base + 7, 1'b1, 1'b0, 1'b1);
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
        ev(base + 15, 1'b1, 1'b0, 1'b1);
        ev(base + 23, 1'b1, 1'b0, 1'b1);
        ev(base + 31, 1'b1, 1'b0, 1'b1);
        ev(base + 39, 1'b1, 1'b0, 1'b1);
`endif
        wait_edges(40);
        btn_in = 1'b0;
        ev(edge_n + 7, 1'b0, 1'b1, 1'b0);
        wait_edges(12);

        // Bounce 1,0,1,0 then low: nothing may happen
        btn_in = 1'b1; wait_edges(1);
        btn_in = 1'b0; wait_edges(1);
        btn_in = 1'b1; wait_edges(1);
        btn_in = 1'b0; wait_edges(12);
        probe(edge_n + 1, 1'b0, 1'b0, 0);
        wait_edges(2);

        // Press, release applied before edge 20
        base = edge_n;
        btn_in = 1'b1;
        ev(base + 7, 1'b1, 1'b0, 1'b1);
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
        ev(base + 15, 1'b1, 1'b0, 1'b1);
`endif
        ev(base + 26, 1'b0, 1'b1, 1'b0);
        wait_edges(19);
        btn_in = 1'b0;
        wait_edges(12);

        // Two-cycle low glitch while held: level stays high through CHK_LO
        base = edge_n;
        btn_in = 1'b1;
        ev(base + 7, 1'b1, 1'b0, 1'b1);
        probe(base + 14, 1'b0, 1'b0, 1'b1);
        ev(base + 26, 1'b0, 1'b1, 1'b0);
        wait_edges(10);
        btn_in = 1'b0; wait_edges(2);
        btn_in = 1'b1; wait_edges(7);
        btn_in = 1'b0; wait_edges(12);

        // Reset at edges 5-6 of a press; full re-debounce afterwards
        base = edge_n;
        btn_in = 1'b1;
        probe(base + 7, 1'b0, 1'b0, 1'b0);
        ev(base + 13, 1'b1, 1'b0, 1'b1);
        wait_edges(4);
        rst = 1'b1; wait_edges(2);
        rst = 1'b0; wait_edges(7);
        btn_in = 1'b0;
        ev(edge_n + 7, 1'b0, 1'b1, 1'b0);
        wait_edges(12);

        // Reset on the very edge a press is due: reset wins
        base = edge_n;
        btn_in = 1'b1;
        probe(base + 7, 1'b0, 1'b0, 1'b0);
        ev(base + 14, 1'b1, 1'b0, 1'b1);
        wait_edges(6);
        rst = 1'b1; wait_edges(1);
        rst = 1'b0; wait_edges(7);
        btn_in = 1'b0;
        ev(edge_n + 7, 1'b0, 1'b1, 1'b0);
        wait_edges(12);

        done = 1'b1;
        wait_edges(3);
        $display("FAIL monitor did not conclude got done=%b required summary", done);
        $fatal(1);
    end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 The block SHALL provide parameter DEBOUNCE_CYCLES, default 4, meaning the number of consecutive stable synchronized samples required to accept a level change (legal range 2..2^20).
REQ-002 The block SHALL provide parameter REPEAT_CYCLES, default 8, meaning the auto-repeat period in clk cycles (legal range 2..2^20, used only when the auto-repeat feature is compiled in).
REQ-003 The block SHALL have port `clk`, input, 1 bit: the single clock; all flops sample on its rising edge.
REQ-004 The block SHALL have port `rst`, input, 1 bit: reset, synchronous to `clk` and active-high.
REQ-005 The block SHALL have port `btn_in`, input, 1 bit: raw, bouncy, asynchronous push-button level.
REQ-006 The block SHALL have port `btn_level`, output, 1 bit: registered debounced button level.
REQ-007 The block SHALL have port `btn_press`, output, 1 bit: registered one-cycle pulse per accepted press (and per auto-repeat); it drives a downstream counter's increment enable.
REQ-008 The block SHALL have port `btn_release`, output, 1 bit: registered one-cycle pulse per accepted release.

Function
REQ-009 `btn_in` SHALL pass through a 2-flop synchronizer; the FSM SHALL see only the second-flop output, `btn_sync`.
REQ-010 The FSM SHALL have exactly four states:
- IDLE: stable low.
- CHK_HI: qualifying high.
- HELD: stable high.
- CHK_LO: qualifying low.
REQ-011 IDLE SHALL go to CHK_HI when `btn_sync`=1, clearing the stability counter to 0.
REQ-012 CHK_HI SHALL return to IDLE on `btn_sync`=0 with no pulse, otherwise increment the counter.
REQ-013 CHK_HI SHALL go to HELD when the counter equals DEBOUNCE_CYCLES-1 and `btn_sync`=1.
REQ-014 HELD SHALL go to CHK_LO when `btn_sync`=0, clearing the counter.
REQ-015 CHK_LO SHALL be symmetric to CHK_HI:
- return to HELD on `btn_sync`=1, with no pulse;
- go to IDLE when the counter equals DEBOUNCE_CYCLES-1 and `btn_sync`=0.
REQ-016 `btn_press` SHALL be high for exactly the one cycle following the CHK_HI->HELD edge.
REQ-017 `btn_release` SHALL be high for exactly the one cycle following the CHK_LO->IDLE edge.
REQ-018 Latency: with `btn_in` stable from before rising edge 1, `btn_press` (or `btn_release`) SHALL rise after edge DEBOUNCE_CYCLES+3.
REQ-019 `btn_level` SHALL rise with `btn_press`, fall with `btn_release`, and hold 1 throughout CHK_LO.
REQ-020 Any bounce shorter than DEBOUNCE_CYCLES synchronized samples SHALL produce no pulse and no `btn_level` change.
REQ-021 `btn_press` and `btn_release` SHALL never be high in the same cycle.
REQ-022 The stability counter width SHALL be $clog2(DEBOUNCE_CYCLES).
REQ-023 The stability counter SHALL never wrap, because every state exit clears it.

Reset
REQ-024 `rst` high at a rising edge SHALL force:
- both synchronizer flops to 0;
- the FSM to IDLE;
- all counters to 0;
- `btn_level`, `btn_press` and `btn_release` to 0.
REQ-025 Reset SHALL take priority over every other event, including a pulse due in the same cycle.
REQ-026 If the button is held while `rst` deasserts, the block SHALL perform a full debounce and emit one `btn_press` at edge DEBOUNCE_CYCLES+3 after the first edge with `rst`=0.

Configuration
REQ-027 With macro BTN_DEBOUNCE_AUTOREPEAT_EN defined:
- a repeat counter of width $clog2(REPEAT_CYCLES) SHALL clear on entry to HELD and increment every cycle in HELD;
- when it equals REPEAT_CYCLES-1, `btn_press` SHALL pulse for one cycle and the counter SHALL wrap to 0;
- the counter SHALL clear on any exit from HELD.
REQ-028 Without BTN_DEBOUNCE_AUTOREPEAT_EN, no repeat counter SHALL exist and exactly one `btn_press` SHALL occur per accepted press.

Structure
REQ-029 Package btn_debounce_pkg SHALL hold:
- the FSM state typedef (IDLE, CHK_HI, HELD, CHK_LO);
- the constants DEFAULT_DEBOUNCE_CYCLES=4 and DEFAULT_REPEAT_CYCLES=8.
REQ-030 The synchronizer SHALL be a separate sub-module, sync_2ff, 1 bit wide, with `clk` and `rst`.

Verification (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8)
REQ-031 Clean press: `btn_in` 0->1 before edge 1 and held -> `btn_press`=1 only after edge 7; `btn_level`=1 from edge 7.
REQ-032 Bounce: `btn_in` toggles 1,0,1,0 on edges 1-4, then 0 -> no pulse, `btn_level` stays 0.
REQ-033 Release: after REQ-031, `btn_in`->0 before edge 20 -> `btn_release`=1 only after edge 26; `btn_level`=0 from edge 26.
REQ-034 Glitch while held: `btn_in` low for 2 cycles in HELD -> no `btn_release`; `btn_level` stays 1.
REQ-035 Reset mid-press: `rst`=1 at edge 5 of a press, deasserted at edge 6, `btn_in` held -> no pulse at edge 7; single `btn_press` after edge 13.
REQ-036 With BTN_DEBOUNCE_AUTOREPEAT_EN and the button held 40 cycles from edge 1 -> `btn_press` after edges 7, 15, 23, 31 and 39; without the macro, after edge 7 only.
